// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sweep initial-value helper for regfile_mp
package regfile_pkg;

    localparam int unsigned INIT_MOD = 100;

    typedef enum logic {SWEEP, READY} state_t;

    // (idx*idx) mod 100 always fits in 7 bits; callers zero-extend it to WIDTH
    function automatic logic [6:0] init_value(input int unsigned idx);
        int unsigned r;
        r = idx % INIT_MOD;
        return 7'((r * r) % INIT_MOD);
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: sweep FSM that rewrites every register with its initial value
module regfile_init_seq import regfile_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              init,
    output logic              busy,
    output logic              sweepWe,
    output logic [ADDR_W-1:0] sweepAddr,
    output logic [WIDTH-1:0]  sweepData
);

    state_t            state, nextState;
    logic [ADDR_W-1:0] ptr, ptrNext;

    // state and sweep pointer; reset restarts the sweep from register 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= nextState;
            ptr   <= ptrNext;
        end
    end

    // leave SWEEP after writing the last register; init restarts it from READY
    always_comb begin
        nextState = state;
        ptrNext   = ptr;
        if (state == SWEEP) begin
            ptrNext = ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) nextState = READY;
        end else if (init) begin
            nextState = SWEEP;
            ptrNext   = '0;
        end
    end

    // sweep write port drives the array directly while busy
    always_comb begin
        busy      = state == SWEEP;
        sweepWe   = busy;
        sweepAddr = ptr;
        sweepData = WIDTH'(init_value(32'(ptr)));
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read/1-write register file with init sweep
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [WIDTH-1:0]  readData1,
    output logic [WIDTH-1:0]  readData2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              write,
    input  logic              init,
    output logic              busy
);

    localparam bit ZERO_EN = ZERO_REG != 0;

    logic [WIDTH-1:0]  regs [DEPTH];
    logic              sweepWe, userWrite, hit1, hit2;
    logic [ADDR_W-1:0] sweepAddr;
    logic [WIDTH-1:0]  sweepData;

    regfile_init_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) initSeq (
        .clock     (clock),
        .reset_n   (reset_n),
        .init      (init),
        .busy      (busy),
        .sweepWe   (sweepWe),
        .sweepAddr (sweepAddr),
        .sweepData (sweepData)
    );

    // writes are accepted only when idle, not overridden by init, and not aimed at a hardwired zero
    assign userWrite = !busy && write && !init && !(ZERO_EN && writeReg == '0);

    // array is deliberately not reset; the sweep owns it while busy
    always_ff @(posedge clock) begin
        if (sweepWe) regs[sweepAddr] <= sweepData;
        else if (userWrite) regs[writeReg] <= writeData;
    end

    // read ports: forced to zero while sweeping or when addressing the zero register
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        hit1 = userWrite && writeReg == readReg1;
        hit2 = userWrite && writeReg == readReg2;
`else
        hit1 = 1'b0;
        hit2 = 1'b0;
`endif
        readData1 = (busy || (ZERO_EN && readReg1 == '0)) ? '0 : hit1 ? writeData : regs[readReg1];
        readData2 = (busy || (ZERO_EN && readReg2 == '0)) ? '0 : hit2 ? writeData : regs[readReg2];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests for regfile_mp with ZERO_REG=1 and ZERO_REG=0 instances
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0, reset_n = 1'b0, write = 1'b0, init = 1'b0;
    logic [4:0]  readReg1 = '0, readReg2 = '0, writeReg = '0;
    logic [31:0] writeData = '0;
    logic [31:0] rd1, rd2, rd1Nz, rd2Nz;
    logic        busy, busyNz;
    int          passCount = 0, checkCount = 0;

    always #5 clock = ~clock;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
        .clock(clock), .reset_n(reset_n), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1), .readData2(rd2), .writeReg(writeReg), .writeData(writeData),
        .write(write), .init(init), .busy(busy)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dutNz (
        .clock(clock), .reset_n(reset_n), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1Nz), .readData2(rd2Nz), .writeReg(writeReg), .writeData(writeData),
        .write(write), .init(init), .busy(busyNz)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        #1;
        checkCount++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passCount++;
        checkCount++; if (rd1 !== 32'd0) $display("FAIL reset_rd1: got %0h expected 0", rd1); else passCount++;
        checkCount++; if (rd2 !== 32'd0) $display("FAIL reset_rd2: got %0h expected 0", rd2); else passCount++;
        tick;
        tick;
        reset_n = 1'b1;
        wait_idle(n);
        checkCount++; if (n != 32) $display("FAIL reset_sweep_len: got %0d expected 32", n); else passCount++;
        checkCount++; if (busyNz !== 1'b0) $display("FAIL reset_busy_nz: got %b expected 0", busyNz); else passCount++;
    endtask

    task automatic test_sweep_values;
        readReg1 = 5'd5; readReg2 = 5'd12; #1;
        checkCount++; if (rd1 !== 32'd25) $display("FAIL sweep_reg5: got %0d expected 25", rd1); else passCount++;
        checkCount++; if (rd2 !== 32'd44) $display("FAIL sweep_reg12: got %0d expected 44", rd2); else passCount++;
        readReg1 = 5'd31; readReg2 = 5'd0; #1;
        checkCount++; if (rd1 !== 32'd61) $display("FAIL sweep_reg31: got %0d expected 61", rd1); else passCount++;
        checkCount++; if (rd2 !== 32'd0) $display("FAIL sweep_reg0: got %0d expected 0", rd2); else passCount++;
        checkCount++; if (rd2Nz !== 32'd0) $display("FAIL sweep_reg0_nz: got %0d expected 0", rd2Nz); else passCount++;
        readReg2 = 5'd10; #1;
        checkCount++; if (rd2 !== 32'd0) $display("FAIL sweep_reg10: got %0d expected 0", rd2); else passCount++;
    endtask

    task automatic test_write_bypass;
        logic [31:0] exp;
        readReg1 = 5'd7; readReg2 = 5'd7;
        writeReg = 5'd7; writeData = 32'hDEADBEEF; write = 1'b1; #1;
        exp = BYP ? 32'hDEADBEEF : 32'd49;
        checkCount++; if (rd1 !== exp) $display("FAIL write_same_rd1: got %0h expected %0h", rd1, exp); else passCount++;
        checkCount++; if (rd2 !== exp) $display("FAIL write_same_rd2: got %0h expected %0h", rd2, exp); else passCount++;
        tick;
        write = 1'b0; #1;
        checkCount++; if (rd1 !== 32'hDEADBEEF) $display("FAIL write_next_rd1: got %0h expected deadbeef", rd1); else passCount++;
        checkCount++; if (rd2 !== 32'hDEADBEEF) $display("FAIL write_next_rd2: got %0h expected deadbeef", rd2); else passCount++;
    endtask

    task automatic test_zero_reg;
        logic [31:0] exp;
        readReg1 = 5'd0; writeReg = 5'd0; writeData = 32'h1234; write = 1'b1; #1;
        exp = BYP ? 32'h1234 : 32'h0;
        checkCount++; if (rd1 !== 32'd0) $display("FAIL zero_same: got %0h expected 0", rd1); else passCount++;
        checkCount++; if (rd1Nz !== exp) $display("FAIL zero_nz_same: got %0h expected %0h", rd1Nz, exp); else passCount++;
        tick;
        write = 1'b0; #1;
        checkCount++; if (rd1 !== 32'd0) $display("FAIL zero_next: got %0h expected 0", rd1); else passCount++;
        checkCount++; if (rd1Nz !== 32'h1234) $display("FAIL zero_nz_next: got %0h expected 1234", rd1Nz); else passCount++;
    endtask

    task automatic test_write_during_sweep;
        int n;
        init = 1'b1;
        tick;
        init = 1'b0;
        checkCount++; if (busy !== 1'b1) $display("FAIL sweep_start_busy: got %b expected 1", busy); else passCount++;
        readReg1 = 5'd5; #1;
        checkCount++; if (rd1 !== 32'd0) $display("FAIL sweep_forced_zero: got %0h expected 0", rd1); else passCount++;
        writeReg = 5'd3; writeData = 32'hFF; write = 1'b1;
        tick;
        tick;
        write = 1'b0;
        wait_idle(n);
        readReg1 = 5'd3; readReg2 = 5'd7; #1;
        checkCount++; if (rd1 !== 32'd9) $display("FAIL sweep_write_dropped: got %0h expected 9", rd1); else passCount++;
        checkCount++; if (rd2 !== 32'd49) $display("FAIL resweep_reg7: got %0h expected 49", rd2); else passCount++;
    endtask

    task automatic test_init_priority;
        int n;
        readReg1 = 5'd4; writeReg = 5'd4; writeData = 32'hAA; write = 1'b1; init = 1'b1; #1;
        checkCount++; if (rd1 !== 32'd16) $display("FAIL init_prio_same: got %0h expected 10", rd1); else passCount++;
        tick;
        write = 1'b0; init = 1'b0;
        checkCount++; if (busy !== 1'b1) $display("FAIL init_prio_busy: got %b expected 1", busy); else passCount++;
        wait_idle(n);
        checkCount++; if (n != 32) $display("FAIL init_prio_len: got %0d expected 32", n); else passCount++;
        checkCount++; if (rd1 !== 32'd16) $display("FAIL init_prio_reg4: got %0h expected 10", rd1); else passCount++;
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        init = 1'b1;
        tick;
        init = 1'b0;
        repeat (10) tick;
        reset_n = 1'b0; #1;
        checkCount++; if (busy !== 1'b1) $display("FAIL mid_reset_busy: got %b expected 1", busy); else passCount++;
        checkCount++; if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL mid_reset_rd: got %0h/%0h expected 0/0", rd1, rd2); else passCount++;
        tick;
        reset_n = 1'b1;
        wait_idle(n);
        checkCount++; if (n != 32) $display("FAIL mid_reset_len: got %0d expected 32", n); else passCount++;
    endtask

    task automatic test_reset_ready;
        int n;
        readReg1 = 5'd5; readReg2 = 5'd12; #1;
        checkCount++; if (rd1 !== 32'd25) $display("FAIL ready_reg5: got %0d expected 25", rd1); else passCount++;
        reset_n = 1'b0; #1;
        checkCount++; if (rd1 !== 32'd0 || busy !== 1'b1) $display("FAIL async_reset: got rd1=%0h busy=%b expected 0/1", rd1, busy); else passCount++;
        tick;
        reset_n = 1'b1;
        wait_idle(n);
        checkCount++; if (rd2 !== 32'd44) $display("FAIL ready_reg12: got %0d expected 44", rd2); else passCount++;
    endtask

    initial begin
        test_reset;
        test_sweep_values;
        test_write_bypass;
        test_zero_reg;
        test_write_during_sweep;
        test_init_priority;
        test_reset_mid_sweep;
        test_reset_ready;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
